// File: rtl/sat_stream_buffer_if.sv
// Avalon-ST bundle around the saturation-stage output buffer: valid-only sink
// in, ready/valid source out. The buffer takes the slave side.
interface sat_stream_buffer_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int ERROR_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  ast_sink_data;
  logic [ERROR_WIDTH-1:0] ast_sink_error;
  logic                   ast_sink_valid;
  logic                   ast_source_ready;
  logic [DATA_WIDTH-1:0]  ast_source_data;
  logic [ERROR_WIDTH-1:0] ast_source_error;
  logic                   ast_source_valid;

  // Upstream producer plus downstream consumer, seen from outside the buffer.
  modport master (
    output ast_sink_data, ast_sink_error, ast_sink_valid, ast_source_ready,
    input  ast_source_data, ast_source_error, ast_source_valid
  );

  modport slave (
    input  ast_sink_data, ast_sink_error, ast_sink_valid, ast_source_ready,
    output ast_source_data, ast_source_error, ast_source_valid
  );
endinterface

// File: rtl/sat_stream_buffer.sv
// Show-ahead FIFO behind the 35-to-12-bit saturation stage, with fill level,
// sticky overflow and a saturating count of clipped samples.
module sat_stream_buffer #(
  parameter int DATA_WIDTH     = 12,
  parameter int ERROR_WIDTH    = 2,
  parameter int ADDR_WIDTH     = 4,
  parameter int CLIP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  sat_stream_buffer_if.slave        st,
  input  logic                      clear_stats,
  output logic [ADDR_WIDTH:0]       fill_level,
  output logic                      overflow,
  output logic [CLIP_CNT_WIDTH-1:0] clip_count
);

  localparam int                   DEPTH    = 2 ** ADDR_WIDTH;
  localparam int                   ENTRY_W  = DATA_WIDTH + ERROR_WIDTH;
  localparam logic [ADDR_WIDTH:0]  FULL_LVL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  LVL_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]  LVL_TWO  = (ADDR_WIDTH + 1)'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [CLIP_CNT_WIDTH-1:0] CLIP_ONE = CLIP_CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  wr_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr;
  logic [ADDR_WIDTH-1:0]  rd_ptr_next;
  logic [ADDR_WIDTH:0]    fill_next;
  logic [DATA_WIDTH-1:0]  src_data_q;
  logic [ERROR_WIDTH-1:0] src_error_q;
  logic                   src_valid_q;
  logic                   rd;
  logic                   wr;
  logic                   drop;
  logic                   full;
  logic                   clip_hit;

  assign full        = (fill_level == FULL_LVL);
  assign rd          = src_valid_q && st.ast_source_ready;
  assign wr          = st.ast_sink_valid && (!full || rd);
  assign drop        = st.ast_sink_valid && full && !rd;
  assign clip_hit    = (st.ast_sink_data == MAX_POS) || (st.ast_sink_data == MIN_NEG);
  assign rd_ptr_next = rd_ptr + PTR_ONE;

  assign st.ast_source_data  = src_data_q;
  assign st.ast_source_error = src_error_q;
  assign st.ast_source_valid = src_valid_q;

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    fill_next = fill_level;
    if (wr && !rd)      fill_next = fill_level + LVL_ONE;
    else if (rd && !wr) fill_next = fill_level - LVL_ONE;
  end

  // NOTE: sample storage has no reset; only pointers and fill level define what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {st.ast_sink_data, st.ast_sink_error};
  end

  // NOTE: all state registers use non-blocking assignment so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill_level  <= '0;
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      src_error_q <= '0;
      overflow    <= 1'b0;
      clip_count  <= '0;
    end else begin
      fill_level  <= fill_next;
      src_valid_q <= (fill_next != '0);
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr_next;

      // Head register mirrors mem[rd_ptr]. With a single entry the successor
      // is not in memory yet, so a concurrent write bypasses straight in.
      if (rd) begin
        if (fill_level >= LVL_TWO) begin
          {src_data_q, src_error_q} <= mem[rd_ptr_next];
        end else if (wr) begin
          src_data_q  <= st.ast_sink_data;
          src_error_q <= st.ast_sink_error;
        end
      end else if (wr && fill_level == '0) begin
        src_data_q  <= st.ast_sink_data;
        src_error_q <= st.ast_sink_error;
      end

      if (clear_stats)  overflow <= 1'b0;
      else if (drop)    overflow <= 1'b1;

      if (clear_stats) begin
        clip_count <= '0;
      end else if (wr && clip_hit && clip_count != '1) begin
        clip_count <= clip_count + CLIP_ONE;
      end
    end
  end

endmodule
